// File: rtl/dmem_pkg.sv
// Shared types for the data-memory arbiter.
// DMEM_ARB_WINDOW_CHK_EN adds a local-error flag to each response-FIFO entry.
package dmem_pkg;

    localparam int unsigned WORD_BYTES = 4;
    localparam int unsigned WORD_SHIFT = $clog2(WORD_BYTES);

    typedef struct packed {
        logic [31:0] addr;
        logic        we;
        logic [3:0]  be;
        logic [31:0] wdata;
    } obi_req_t;

    typedef struct packed {
        logic [31:0] rdata;
        logic        err;
    } obi_rsp_t;

    typedef enum logic {
        ARB_CORE = 1'b0,
        ARB_AES  = 1'b1
    } arb_id_e;

    typedef struct packed {
        arb_id_e id;
`ifdef DMEM_ARB_WINDOW_CHK_EN
        logic    lerr;
`endif
    } fifo_ent_t;

    // Word-granular check: base <= addr < base + size.
    function automatic logic in_window(input logic [31:0] addr, input logic [31:0] base,
                                       input logic [31:0] size);
        logic [31:0] w_lim;
        w_lim = base + size;
        return ((addr >> WORD_SHIFT) >= (base >> WORD_SHIFT)) &&
               ((addr >> WORD_SHIFT) < (w_lim >> WORD_SHIFT));
    endfunction

endpackage

// File: rtl/dmem_arbiter_resp_id_fifo.sv
// Response-ID FIFO: remembers which requester owns each outstanding access.
// A push is accepted while full if an entry leaves in the same cycle.
module resp_id_fifo
    import dmem_pkg::*;
#(
    parameter int unsigned DEPTH = 2
) (
    input  logic      clk_i,
    input  logic      rst_i,
    input  logic      i_push,
    input  fifo_ent_t i_ent,
    input  logic      i_pop,
    output fifo_ent_t o_head,
    output logic      o_empty,
    output logic      o_full
);

    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(DEPTH + 1);

    fifo_ent_t         r_mem [DEPTH];
    logic [PW-1:0]     r_wptr;
    logic [PW-1:0]     r_rptr;
    logic [CW-1:0]     r_count;
    logic              w_push_ok;
    logic              w_pop_ok;

    assign o_empty   = (r_count == '0);
    assign o_full    = (r_count == CW'(DEPTH));
    assign w_push_ok = i_push & (~o_full | i_pop);
    assign w_pop_ok  = i_pop & ~o_empty;
    assign o_head    = r_mem[r_rptr];

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push_ok) begin
                r_wptr <= ptr_inc(r_wptr);
            end
            if (w_pop_ok) begin
                r_rptr <= ptr_inc(r_rptr);
            end
            if (w_push_ok && !w_pop_ok) begin
                r_count <= r_count + CW'(1);
            end else if (!w_push_ok && w_pop_ok) begin
                r_count <= r_count - CW'(1);
            end
        end
    end

    // Storage is not reset; the pointers and count alone define validity.
    always_ff @(posedge clk_i) begin
        if (w_push_ok) begin
            r_mem[r_wptr] <= i_ent;
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Round-robin arbiter of the core LSU (m0) and AES master (m1) onto one OBI data port.
// DMEM_ARB_WINDOW_CHK_EN: m1 accesses outside the AES window are answered locally with an error.
module dmem_arbiter
    import dmem_pkg::*;
#(
    parameter int unsigned MAX_OUTST = 2,
    parameter logic [31:0] WIN_BASE  = 32'h0000_0180,
    parameter logic [31:0] WIN_SIZE  = 32'h0000_0080
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        m0_req_i,
    output logic        m0_gnt_o,
    input  logic [31:0] m0_addr_i,
    input  logic        m0_we_i,
    input  logic [3:0]  m0_be_i,
    input  logic [31:0] m0_wdata_i,
    output logic        m0_rvalid_o,
    output logic [31:0] m0_rdata_o,
    output logic        m0_err_o,
    input  logic        m1_req_i,
    output logic        m1_gnt_o,
    input  logic [31:0] m1_addr_i,
    input  logic        m1_we_i,
    input  logic [3:0]  m1_be_i,
    input  logic [31:0] m1_wdata_i,
    output logic        m1_rvalid_o,
    output logic [31:0] m1_rdata_o,
    output logic        m1_err_o,
    output logic        mem_req_o,
    input  logic        mem_gnt_i,
    output logic [31:0] mem_addr_o,
    output logic        mem_we_o,
    output logic [3:0]  mem_be_o,
    output logic [31:0] mem_wdata_o,
    input  logic        mem_rvalid_i,
    input  logic [31:0] mem_rdata_i,
    input  logic        mem_err_i,
    output logic        orphan_o
);

    arb_id_e   r_rr_last;
    logic      r_orphan;
    arb_id_e   w_sel;
    obi_req_t  w_m0_req;
    obi_req_t  w_m1_req;
    obi_req_t  w_sel_req;
    obi_rsp_t  w_rsp;
    fifo_ent_t w_push_ent;
    fifo_ent_t w_head;
    logic      w_empty;
    logic      w_full;
    logic      w_any_req;
    logic      w_can_issue;
    logic      w_grant;
    logic      w_pop;
    logic      w_lerr;
    logic      w_head_lerr;

    assign w_m0_req = '{addr: m0_addr_i, we: m0_we_i, be: m0_be_i, wdata: m0_wdata_i};
    assign w_m1_req = '{addr: m1_addr_i, we: m1_we_i, be: m1_be_i, wdata: m1_wdata_i};

    always_comb begin
        w_sel = ARB_CORE;
        if (m0_req_i && m1_req_i) begin
            w_sel = (r_rr_last == ARB_CORE) ? ARB_AES : ARB_CORE;
        end else if (m1_req_i) begin
            w_sel = ARB_AES;
        end
    end

    assign w_sel_req = (w_sel == ARB_AES) ? w_m1_req : w_m0_req;

`ifdef DMEM_ARB_WINDOW_CHK_EN
    assign w_lerr      = (w_sel == ARB_AES) && !in_window(m1_addr_i, WIN_BASE, WIN_SIZE);
    assign w_head_lerr = w_head.lerr;
`else
    logic w_unused_win;
    assign w_unused_win = ^{WIN_BASE, WIN_SIZE};
    assign w_lerr       = 1'b0;
    assign w_head_lerr  = 1'b0;
`endif

    // A local-error head retires by itself; otherwise the memory response pops it.
    assign w_pop       = ~w_empty & (mem_rvalid_i | w_head_lerr);
    assign w_any_req   = m0_req_i | m1_req_i;
    assign w_can_issue = ~w_full | w_pop;
    assign mem_req_o   = w_can_issue & w_any_req & ~w_lerr;
    assign w_grant     = w_lerr ? (w_can_issue & w_any_req) : (mem_req_o & mem_gnt_i);
    assign m0_gnt_o    = w_grant & (w_sel == ARB_CORE);
    assign m1_gnt_o    = w_grant & (w_sel == ARB_AES);

    assign mem_addr_o  = mem_req_o ? w_sel_req.addr  : '0;
    assign mem_we_o    = mem_req_o & w_sel_req.we;
    assign mem_be_o    = mem_req_o ? w_sel_req.be    : '0;
    assign mem_wdata_o = mem_req_o ? w_sel_req.wdata : '0;

    always_comb begin
        w_push_ent    = '0;
        w_push_ent.id = w_sel;
`ifdef DMEM_ARB_WINDOW_CHK_EN
        w_push_ent.lerr = w_lerr;
`endif
    end

    resp_id_fifo #(
        .DEPTH (MAX_OUTST)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .i_push  (w_grant),
        .i_ent   (w_push_ent),
        .i_pop   (w_pop),
        .o_head  (w_head),
        .o_empty (w_empty),
        .o_full  (w_full)
    );

    assign w_rsp.rdata = w_head_lerr ? '0 : mem_rdata_i;
    assign w_rsp.err   = w_head_lerr | mem_err_i;

    assign m0_rvalid_o = w_pop & (w_head.id == ARB_CORE);
    assign m1_rvalid_o = w_pop & (w_head.id == ARB_AES);
    assign m0_rdata_o  = m0_rvalid_o ? w_rsp.rdata : '0;
    assign m1_rdata_o  = m1_rvalid_o ? w_rsp.rdata : '0;
    assign m0_err_o    = m0_rvalid_o & w_rsp.err;
    assign m1_err_o    = m1_rvalid_o & w_rsp.err;
    assign orphan_o    = r_orphan;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_rr_last <= ARB_AES;
            r_orphan  <= 1'b0;
        end else begin
            if (w_grant) begin
                r_rr_last <= w_sel;
            end
            if (mem_rvalid_i && (w_empty || w_head_lerr)) begin
                r_orphan <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed table-driven bench for dmem_arbiter, plus hand sequences for reset and window cases.
`timescale 1ns/1ps
module tb_dmem_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        m0_req, m0_gnt, m0_we, m0_rvalid, m0_err;
    logic [31:0] m0_addr, m0_wdata, m0_rdata;
    logic [3:0]  m0_be;
    logic        m1_req, m1_gnt, m1_we, m1_rvalid, m1_err;
    logic [31:0] m1_addr, m1_wdata, m1_rdata;
    logic [3:0]  m1_be;
    logic        mem_req, mem_gnt, mem_we, mem_rvalid, mem_err, orphan;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [3:0]  mem_be;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    dmem_arbiter dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .m0_req_i     (m0_req),
        .m0_gnt_o     (m0_gnt),
        .m0_addr_i    (m0_addr),
        .m0_we_i      (m0_we),
        .m0_be_i      (m0_be),
        .m0_wdata_i   (m0_wdata),
        .m0_rvalid_o  (m0_rvalid),
        .m0_rdata_o   (m0_rdata),
        .m0_err_o     (m0_err),
        .m1_req_i     (m1_req),
        .m1_gnt_o     (m1_gnt),
        .m1_addr_i    (m1_addr),
        .m1_we_i      (m1_we),
        .m1_be_i      (m1_be),
        .m1_wdata_i   (m1_wdata),
        .m1_rvalid_o  (m1_rvalid),
        .m1_rdata_o   (m1_rdata),
        .m1_err_o     (m1_err),
        .mem_req_o    (mem_req),
        .mem_gnt_i    (mem_gnt),
        .mem_addr_o   (mem_addr),
        .mem_we_o     (mem_we),
        .mem_be_o     (mem_be),
        .mem_wdata_o  (mem_wdata),
        .mem_rvalid_i (mem_rvalid),
        .mem_rdata_i  (mem_rdata),
        .mem_err_i    (mem_err),
        .orphan_o     (orphan)
    );

    typedef struct {
        logic        rst;
        logic        m0r;
        logic [31:0] m0a;
        logic        m1r;
        logic [31:0] m1a;
        logic        gnt;
        logic        rv;
        logic [31:0] rd;
        logic        merr;
        logic        eg0;
        logic        eg1;
        logic        ereq;
        logic [31:0] eaddr;
        logic        erv0;
        logic        erv1;
        logic [31:0] erd0;
        logic [31:0] erd1;
        logic        eer0;
        logic        eer1;
        logic        eorph;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t v(logic r, logic m0r, logic [31:0] m0a, logic m1r,
                               logic [31:0] m1a, logic g, logic rv, logic [31:0] rd,
                               logic me, logic eg0, logic eg1, logic ereq,
                               logic [31:0] eaddr, logic erv0, logic erv1,
                               logic [31:0] erd0, logic [31:0] erd1, logic eer0,
                               logic eer1, logic eorph);
        vec_t x;
        x.rst = r;     x.m0r = m0r;   x.m0a = m0a;     x.m1r = m1r;   x.m1a = m1a;
        x.gnt = g;     x.rv = rv;     x.rd = rd;       x.merr = me;
        x.eg0 = eg0;   x.eg1 = eg1;   x.ereq = ereq;   x.eaddr = eaddr;
        x.erv0 = erv0; x.erv1 = erv1; x.erd0 = erd0;   x.erd1 = erd1;
        x.eer0 = eer0; x.eer1 = eer1; x.eorph = eorph;
        return x;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic r, input logic m0r, input logic [31:0] m0a,
                         input logic m1r, input logic [31:0] m1a, input logic g,
                         input logic rv, input logic [31:0] rd, input logic me);
        @(negedge clk);
        rst = r; m0_req = m0r; m0_addr = m0a; m1_req = m1r; m1_addr = m1a;
        mem_gnt = g; mem_rvalid = rv; mem_rdata = rd; mem_err = me;
        #1;
    endtask

    task automatic check_row(input int idx, input vec_t x);
        string s;
        s = $sformatf("row%0d", idx);
        chk({s, ".m0_gnt"}, 32'(m0_gnt), 32'(x.eg0));
        chk({s, ".m1_gnt"}, 32'(m1_gnt), 32'(x.eg1));
        chk({s, ".mem_req"}, 32'(mem_req), 32'(x.ereq));
        if (x.ereq) begin
            chk({s, ".mem_addr"}, mem_addr, x.eaddr);
            chk({s, ".mem_we"}, 32'(mem_we), 32'(x.eg1 | (x.m1r & ~x.m0r)));
            chk({s, ".mem_wdata"}, mem_wdata,
                (x.eg1 | (x.m1r & ~x.m0r)) ? 32'h2222_2222 : 32'h1111_1111);
        end
        chk({s, ".m0_rvalid"}, 32'(m0_rvalid), 32'(x.erv0));
        chk({s, ".m1_rvalid"}, 32'(m1_rvalid), 32'(x.erv1));
        chk({s, ".m0_rdata"}, m0_rdata, x.erd0);
        chk({s, ".m1_rdata"}, m1_rdata, x.erd1);
        chk({s, ".m0_err"}, 32'(m0_err), 32'(x.eer0));
        chk({s, ".m1_err"}, 32'(m1_err), 32'(x.eer1));
        chk({s, ".orphan"}, 32'(orphan), 32'(x.eorph));
    endtask

    localparam logic [31:0] A0 = 32'h100;
    localparam logic [31:0] A1 = 32'h1C4;

    initial begin
        rst = 1'b1; m0_req = 0; m0_addr = 0; m1_req = 0; m1_addr = 0;
        mem_gnt = 0; mem_rvalid = 0; mem_rdata = 0; mem_err = 0;
        m0_we = 1'b0; m0_be = 4'hF; m0_wdata = 32'h1111_1111;
        m1_we = 1'b1; m1_be = 4'h3; m1_wdata = 32'h2222_2222;

        // Reset and idle, then memory stall, then T1.
        tbl.push_back(v(1, 0,0,0,0, 0,0,0,0, 0,0,0,0, 0,0,0,0,0,0,0));
        tbl.push_back(v(0, 0,0,0,0, 0,0,0,0, 0,0,0,0, 0,0,0,0,0,0,0));
        tbl.push_back(v(0, 1,32'h1C0,0,0, 0,0,0,0, 0,0,1,32'h1C0, 0,0,0,0,0,0,0));
        tbl.push_back(v(0, 1,32'h1C0,0,0, 1,0,0,0, 1,0,1,32'h1C0, 0,0,0,0,0,0,0));
        tbl.push_back(v(0, 0,0,0,0, 0,1,32'hCAFE_F00D,0, 0,0,0,0, 1,0,32'hCAFE_F00D,0,0,0,0));
        // T2: both requesting, grants alternate from m0; one response carries an error.
        tbl.push_back(v(1, 0,0,0,0, 0,0,0,0, 0,0,0,0, 0,0,0,0,0,0,0));
        tbl.push_back(v(0, 1,A0,1,A1, 1,0,0,0,     1,0,1,A0, 0,0,0,0,0,0,0));
        tbl.push_back(v(0, 1,A0,1,A1, 1,1,32'hD1,0, 0,1,1,A1, 1,0,32'hD1,0,0,0,0));
        tbl.push_back(v(0, 1,A0,1,A1, 1,1,32'hD2,1, 1,0,1,A0, 0,1,0,32'hD2,0,1,0));
        tbl.push_back(v(0, 1,A0,1,A1, 1,1,32'hD3,0, 0,1,1,A1, 1,0,32'hD3,0,0,0,0));
        tbl.push_back(v(0, 1,A0,1,A1, 1,1,32'hD4,0, 1,0,1,A0, 0,1,0,32'hD4,0,0,0));
        tbl.push_back(v(0, 1,A0,1,A1, 1,1,32'hD5,0, 0,1,1,A1, 1,0,32'hD5,0,0,0,0));
        tbl.push_back(v(0, 0,0,0,0,   0,1,32'hD6,0, 0,0,0,0,  0,1,0,32'hD6,0,0,0));
        // T3: FIFO fills, stalls, then issues in the cycle of the first response.
        tbl.push_back(v(1, 0,0,0,0, 0,0,0,0, 0,0,0,0, 0,0,0,0,0,0,0));
        tbl.push_back(v(0, 1,32'h300,0,0, 1,0,0,0,     1,0,1,32'h300, 0,0,0,0,0,0,0));
        tbl.push_back(v(0, 1,32'h300,0,0, 1,0,0,0,     1,0,1,32'h300, 0,0,0,0,0,0,0));
        tbl.push_back(v(0, 1,32'h300,0,0, 1,0,0,0,     0,0,0,0,       0,0,0,0,0,0,0));
        tbl.push_back(v(0, 1,32'h300,0,0, 1,1,32'hE1,0, 1,0,1,32'h300, 1,0,32'hE1,0,0,0,0));
        tbl.push_back(v(0, 0,0,0,0, 0,1,32'hE2,0, 0,0,0,0, 1,0,32'hE2,0,0,0,0));
        tbl.push_back(v(0, 0,0,0,0, 0,1,32'hE3,0, 0,0,0,0, 1,0,32'hE3,0,0,0,0));
        // m1 alone: granted every cycle.
        tbl.push_back(v(0, 0,0,1,32'h1A0, 1,0,0,0,      0,1,1,32'h1A0, 0,0,0,0,0,0,0));
        tbl.push_back(v(0, 0,0,1,32'h1A0, 1,1,32'hF1,0, 0,1,1,32'h1A0, 0,1,0,32'hF1,0,0,0));
        tbl.push_back(v(0, 0,0,1,32'h1A0, 1,1,32'hF2,0, 0,1,1,32'h1A0, 0,1,0,32'hF2,0,0,0));
        tbl.push_back(v(0, 0,0,0,0, 0,1,32'hF3,0, 0,0,0,0, 0,1,0,32'hF3,0,0,0));
        // T4: orphan response with an empty FIFO; flag is sticky.
        tbl.push_back(v(0, 0,0,0,0, 0,1,32'h55,0, 0,0,0,0, 0,0,0,0,0,0,0));
        tbl.push_back(v(0, 0,0,0,0, 0,0,0,0,      0,0,0,0, 0,0,0,0,0,0,1));
        tbl.push_back(v(0, 1,32'h1C0,0,0, 1,0,0,0, 1,0,1,32'h1C0, 0,0,0,0,0,0,1));
        tbl.push_back(v(0, 0,0,0,0, 0,1,32'h66,0, 0,0,0,0, 1,0,32'h66,0,0,0,1));

        for (int i = 0; i < tbl.size(); i++) begin
            drive(tbl[i].rst, tbl[i].m0r, tbl[i].m0a, tbl[i].m1r, tbl[i].m1a,
                  tbl[i].gnt, tbl[i].rv, tbl[i].rd, tbl[i].merr);
            if (!tbl[i].rst) begin
                check_row(i, tbl[i]);
            end
        end

        // T5: reset with two accesses outstanding flushes the FIFO.
        drive(1, 0,0,0,0, 0,0,0,0);
        drive(0, 0,0,0,0, 0,0,0,0);
        chk("t5.orphan_cleared", 32'(orphan), 32'd0);
        drive(0, 1,32'h10,1,32'h1A0, 1,0,0,0);
        chk("t5.first_gnt0", 32'(m0_gnt), 32'd1);
        drive(0, 1,32'h10,1,32'h1A0, 1,0,0,0);
        chk("t5.second_gnt1", 32'(m1_gnt), 32'd1);
        drive(1, 0,0,0,0, 0,0,0,0);
        drive(0, 0,0,0,0, 0,0,0,0);
        chk("t5.idle_outputs", {m0_gnt, m1_gnt, mem_req, m0_rvalid, m1_rvalid, orphan,
                                m0_err, m1_err}, 32'd0);
        chk("t5.idle_data", m0_rdata | m1_rdata | mem_addr | mem_wdata, 32'd0);
        drive(0, 0,0,0,0, 0,1,32'h99,0);
        chk("t5.late_rsp_dropped", 32'({m0_rvalid, m1_rvalid}), 32'd0);
        drive(0, 0,0,0,0, 0,0,0,0);
        chk("t5.late_rsp_orphan", 32'(orphan), 32'd1);
        drive(1, 0,0,0,0, 0,0,0,0);
        drive(0, 0,0,1,32'h1A0, 1,0,0,0);
        chk("t5.m1_gnt_a", 32'(m1_gnt), 32'd1);
        drive(0, 0,0,1,32'h1A0, 1,0,0,0);
        chk("t5.m1_gnt_b", 32'(m1_gnt), 32'd1);
        drive(0, 0,0,1,32'h1A0, 1,0,0,0);
        chk("t5.full_stall", 32'({m1_gnt, mem_req}), 32'd0);
        drive(0, 0,0,0,0, 0,1,32'hA1,0);
        chk("t5.rsp_a", m1_rdata, 32'hA1);
        drive(0, 0,0,0,0, 0,1,32'hA2,0);
        chk("t5.rsp_b", m1_rdata, 32'hA2);

`ifdef DMEM_ARB_WINDOW_CHK_EN
        // T6: out-of-window write answered locally, in-window read follows in order.
        drive(1, 0,0,0,0, 0,0,0,0);
        m1_we = 1'b1;
        drive(0, 0,0,1,32'h040, 1,0,0,0);
        chk("t6.lerr_gnt", 32'(m1_gnt), 32'd1);
        chk("t6.lerr_no_mem", 32'(mem_req), 32'd0);
        m1_we = 1'b0;
        drive(0, 0,0,1,32'h1A0, 1,0,0,0);
        chk("t6.lerr_rsp", 32'({m1_rvalid, m1_err}), 32'h3);
        chk("t6.lerr_rdata", m1_rdata, 32'd0);
        chk("t6.read_mem_req", 32'({mem_req, m1_gnt, mem_we}), 32'h6);
        chk("t6.read_addr", mem_addr, 32'h1A0);
        drive(0, 0,0,0,0, 0,1,32'h77,0);
        chk("t6.read_rsp", 32'({m1_rvalid, m1_err}), 32'h2);
        chk("t6.read_rdata", m1_rdata, 32'h77);
        chk("t6.no_orphan", 32'(orphan), 32'd0);
`endif

        drive(0, 0,0,0,0, 0,0,0,0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
